// File: rtl/mmio_frame_ctrl_if.sv
// CPU data-memory bus between the processor and the MMIO frame controller.
// Carries the store request, the RAM read data and the returned load data.
interface mmio_frame_ctrl_if;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] ram_q;
    logic [31:0] q_dmem;

    modport master (
        output wren,
        output address_dmem,
        output data,
        output ram_q,
        input  q_dmem
    );

    modport slave (
        input  wren,
        input  address_dmem,
        input  data,
        input  ram_q,
        output q_dmem
    );
endinterface

// File: rtl/mmio_frame_ctrl.sv
// MMIO decode for buttons/done/commit/status plus double-buffered X/Y tables.
// CPU fills the back bank, commits, and banks swap at the next vsync.
module mmio_frame_ctrl #(
    parameter int N_OBJ       = 100,
    parameter int X_BASE      = 300,
    parameter int Y_BASE      = 400,
    parameter int BTN_ADDR    = 0,
    parameter int DONE_ADDR   = 1,
    parameter int COMMIT_ADDR = 2,
    parameter int STATUS_ADDR = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_frame_ctrl_if.slave     bus,
    input  logic [2:0]           button,
    input  logic                 vsync_pulse,
    input  logic [6:0]           vga_idx,
    output logic [31:0]          vga_x,
    output logic [31:0]          vga_y,
    output logic                 game_done
);

    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        front;
    logic [15:0] frame_count;
    logic        drop;
    logic [6:0]  copy_idx;
    logic [31:0] bank_x [2][N_OBJ];
    logic [31:0] bank_y [2][N_OBJ];

    logic        x_hit;
    logic        y_hit;
    logic [6:0]  x_idx;
    logic [6:0]  y_idx;
    logic        commit_st;
    logic        status_rd;
    logic        copy_last;

    logic        busy;
    logic        accept;
    logic        copy_en;
    logic        swap;

    assign x_idx = 7'(bus.address_dmem - 12'(X_BASE));
    assign y_idx = 7'(bus.address_dmem - 12'(Y_BASE));

    assign x_hit = bus.wren
                && bus.address_dmem >= 12'(X_BASE)
                && bus.address_dmem <  12'(X_BASE + N_OBJ);
    assign y_hit = bus.wren
                && bus.address_dmem >= 12'(Y_BASE)
                && bus.address_dmem <  12'(Y_BASE + N_OBJ);

    assign commit_st = bus.wren && bus.address_dmem == 12'(COMMIT_ADDR);
    assign status_rd = !bus.wren && bus.address_dmem == 12'(STATUS_ADDR);
    assign copy_last = copy_idx == 7'(N_OBJ - 1);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: commit -> wait vsync -> copy front into back
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (commit_st)   state_nxt = PENDING;
            PENDING: if (vsync_pulse) state_nxt = COPY;
            COPY:    if (copy_last)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // FSM outputs: store acceptance, copy enable, swap strobe
    always_comb begin
        busy    = state != IDLE;
        accept  = state == IDLE;
        copy_en = state == COPY;
        swap    = state == PENDING && vsync_pulse;
    end

    // Bank storage, bank select, frame counter and copy index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    bank_x[b][i] <= '0;
                    bank_y[b][i] <= '0;
                end
            end
            front       <= 1'b0;
            frame_count <= '0;
            copy_idx    <= '0;
        end else begin
            if (copy_en) begin
                bank_x[~front][copy_idx] <= bank_x[front][copy_idx];
                bank_y[~front][copy_idx] <= bank_y[front][copy_idx];
                copy_idx <= copy_last ? 7'd0 : copy_idx + 7'd1;
            end
            if (accept && x_hit) bank_x[~front][x_idx] <= bus.data;
            if (accept && y_hit) bank_y[~front][y_idx] <= bus.data;
            if (swap) begin
                front       <= ~front;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Sticky flags: drop (clear-on-status-read, set wins) and game_done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop      <= 1'b0;
            game_done <= 1'b0;
        end else begin
            drop <= (busy && (x_hit || y_hit)) || (drop && !status_rd);
            if (bus.wren && bus.address_dmem == 12'(DONE_ADDR)
                && bus.data != 32'd0)
                game_done <= 1'b1;
        end
    end

    // Registered renderer read of the front bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x <= '0;
            vga_y <= '0;
        end else if (vga_idx < 7'(N_OBJ)) begin
            vga_x <= bank_x[front][vga_idx];
            vga_y <= bank_y[front][vga_idx];
        end else begin
            vga_x <= '0;
            vga_y <= '0;
        end
    end

    // Combinational CPU load mux
    always_comb begin
        if (bus.address_dmem == 12'(BTN_ADDR))
            bus.q_dmem = {29'b0, button};
        else if (bus.address_dmem == 12'(DONE_ADDR))
            bus.q_dmem = {31'b0, game_done};
        else if (bus.address_dmem == 12'(STATUS_ADDR))
            bus.q_dmem = {frame_count, 14'b0, drop, busy};
        else
            bus.q_dmem = bus.ram_q;
    end

endmodule

// File: tb/tb_mmio_frame_ctrl.sv
// Testbench for mmio_frame_ctrl: directed scenarios plus randomized traffic
// checked against a table-level model of the front/back position images.
module tb_mmio_frame_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  button;
    logic        vsync_pulse;
    logic [6:0]  vga_idx;
    logic [31:0] vga_x;
    logic [31:0] vga_y;
    logic        game_done;

    mmio_frame_ctrl_if bus ();

    mmio_frame_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .button      (button),
        .vsync_pulse (vsync_pulse),
        .vga_idx     (vga_idx),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .game_done   (game_done)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what the renderer shows and what the CPU has staged
    logic [31:0] fx [100];
    logic [31:0] fy [100];
    logic [31:0] bx [100];
    logic [31:0] by [100];
    bit          pending;
    int          busy_left;
    logic [15:0] fc;
    bit          m_drop;
    bit          m_done;
    logic [31:0] e_vx;
    logic [31:0] e_vy;

    task automatic model_reset();
        for (int i = 0; i < 100; i++) begin
            fx[i] = 0; fy[i] = 0; bx[i] = 0; by[i] = 0;
        end
        pending = 0; busy_left = 0; fc = 0;
        m_drop = 0; m_done = 0; e_vx = 0; e_vy = 0;
    endtask

    function automatic bit m_busy();
        return pending || busy_left > 0;
    endfunction

    function automatic logic [31:0] exp_q();
        case (bus.address_dmem)
            12'd0:   return {29'b0, button};
            12'd1:   return {31'b0, m_done};
            12'd3:   return {fc, 14'b0, m_drop, m_busy()};
            default: return bus.ram_q;
        endcase
    endfunction

    task automatic model_edge();
        logic [11:0] a;
        logic [31:0] d;
        bit w, busy, pos, isy;
        int idx;
        a = bus.address_dmem; d = bus.data; w = bus.wren;
        busy = m_busy();
        e_vx = (vga_idx < 100) ? fx[vga_idx] : 32'd0;
        e_vy = (vga_idx < 100) ? fy[vga_idx] : 32'd0;
        pos = 0; isy = 0; idx = 0;
        if (w && a >= 300 && a < 400) begin
            pos = 1; idx = int'(a) - 300;
        end else if (w && a >= 400 && a < 500) begin
            pos = 1; isy = 1; idx = int'(a) - 400;
        end
        if (pos && !busy) begin
            if (isy) by[idx] = d;
            else     bx[idx] = d;
        end
        m_drop = (pos && busy) || (m_drop && !(!w && a == 3));
        if (w && a == 1 && d != 0) m_done = 1;
        if (busy_left > 0) begin
            busy_left--;
        end else if (pending) begin
            if (vsync_pulse) begin
                // front takes the staged image; back ends up a copy of it
                for (int i = 0; i < 100; i++) begin
                    fx[i] = bx[i]; fy[i] = by[i];
                end
                fc++;
                pending = 0;
                busy_left = 100;
            end
        end else if (w && a == 2) begin
            pending = 1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        else begin e_vx = 0; e_vy = 0; end
        #1;
    endtask

    task automatic drive(input bit w, input int a, input logic [31:0] d,
                         input bit v);
        bus.wren = w;
        bus.address_dmem = 12'(a);
        bus.data = d;
        vsync_pulse = v;
    endtask

    task automatic test_reset();
        drive(0, 3, 0, 0);
        #1;
        n_chk++;
        if (bus.q_dmem !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status got=%h exp=%h", bus.q_dmem, 32'd0);
        end
        n_chk++;
        if (game_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got=%b exp=0", game_done);
        end
        for (int i = 0; i < 128; i++) begin
            vga_idx = 7'(i);
            step();
            n_chk++;
            if (vga_x !== 32'd0 || vga_y !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_vga idx=%0d got=%h/%h exp=0/0",
                         i, vga_x, vga_y);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        drive(0, 3, 0, 0);
        #1;
        while (bus.q_dmem[0] && cnt < 300) begin
            step();
            cnt++;
        end
        if (cnt >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout got=busy exp=idle", tag);
        end
    endtask

    task automatic test_frame();
        int cnt;
        drive(1, 305, 32'h64, 0); step();
        drive(1, 405, 32'hC8, 0); step();
        drive(1, 2, $urandom, 0); step();
        drive(0, 3, 0, 0); #1;
        n_chk++;
        if (bus.q_dmem[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_pending_busy got=%b exp=1", bus.q_dmem[0]);
        end
        drive(0, 3, 0, 1); step();
        drive(0, 3, 0, 0);
        vga_idx = 7'd5;
        #1;
        n_chk++;
        if (bus.q_dmem[31:16] !== 16'd1) begin
            n_fail++;
            $display("FAIL frame_count got=%0d exp=1", bus.q_dmem[31:16]);
        end
        cnt = 0;
        while (bus.q_dmem[0] === 1'b1 && cnt < 300) begin
            step();
            cnt++;
            if (cnt == 1) begin
                n_chk++;
                if (vga_x !== 32'h64 || vga_y !== 32'hC8) begin
                    n_fail++;
                    $display("FAIL frame_vga got=%h/%h exp=64/c8",
                             vga_x, vga_y);
                end
            end
        end
        n_chk++;
        if (cnt != 100) begin
            n_fail++;
            $display("FAIL frame_busy_len got=%0d exp=100", cnt);
        end
    endtask

    task automatic test_drop();
        drive(1, 2, 0, 0); step();
        drive(1, 307, 9, 0); step();
        drive(0, 3, 0, 0); #1;
        n_chk++;
        if (bus.q_dmem[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_set got=%b exp=1", bus.q_dmem[1]);
        end
        step();
        n_chk++;
        if (bus.q_dmem[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear got=%b exp=0", bus.q_dmem[1]);
        end
        drive(0, 3, 0, 1); step();
        wait_idle("drop");
        vga_idx = 7'd7;
        step();
        n_chk++;
        if (vga_x !== 32'd0) begin
            n_fail++;
            $display("FAIL drop_vga7 got=%h exp=0", vga_x);
        end
    endtask

    task automatic test_copy_preserve();
        drive(1, 305, 1, 0); step();
        drive(1, 2, 0, 0); step();
        drive(0, 3, 0, 1); step();
        wait_idle("copy");
        vga_idx = 7'd5;
        step();
        n_chk++;
        if (vga_x !== 32'd1 || vga_y !== 32'hC8) begin
            n_fail++;
            $display("FAIL copy_preserve got=%h/%h exp=1/c8", vga_x, vga_y);
        end
    endtask

    task automatic test_game_done();
        drive(1, 1, 0, 0); step();
        n_chk++;
        if (game_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_zero got=%b exp=0", game_done);
        end
        drive(1, 1, 3, 0); step();
        n_chk++;
        if (game_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_set got=%b exp=1", game_done);
        end
        drive(1, 1, 0, 0); step();
        n_chk++;
        if (game_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_sticky got=%b exp=1", game_done);
        end
    endtask

    task automatic test_read_mux();
        logic [31:0] r;
        button = 3'b101;
        drive(0, 0, 0, 0); #1;
        n_chk++;
        if (bus.q_dmem !== 32'd5) begin
            n_fail++;
            $display("FAIL btn_read got=%h exp=5", bus.q_dmem);
        end
        r = $urandom;
        bus.ram_q = r;
        drive(0, 50, 0, 0); #1;
        n_chk++;
        if (bus.q_dmem !== r) begin
            n_fail++;
            $display("FAIL ram_read got=%h exp=%h", bus.q_dmem, r);
        end
        vga_idx = 7'd120;
        step();
        n_chk++;
        if (vga_x !== 32'd0 || vga_y !== 32'd0) begin
            n_fail++;
            $display("FAIL vga_oob got=%h/%h exp=0/0", vga_x, vga_y);
        end
    endtask

    task automatic test_random();
        int sel, a;
        logic [31:0] e;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = sel;
                4, 5:       a = 300 + $urandom_range(0, 99);
                6, 7:       a = 400 + $urandom_range(0, 99);
                8:          a = $urandom_range(200, 299);
                default:    a = $urandom_range(0, 4095);
            endcase
            drive($urandom_range(0, 1) == 1, a, $urandom_range(0, 3) == 0
                  ? 32'd0 : $urandom, $urandom_range(0, 19) == 0);
            bus.ram_q = $urandom;
            button = 3'($urandom);
            vga_idx = 7'($urandom);
            #1;
            e = exp_q();
            n_chk++;
            if (bus.q_dmem !== e) begin
                n_fail++;
                $display("FAIL rand_q n=%0d addr=%0d got=%h exp=%h",
                         n, a, bus.q_dmem, e);
            end
            step();
            n_chk++;
            if (vga_x !== e_vx || vga_y !== e_vy || game_done !== m_done) begin
                n_fail++;
                $display("FAIL rand_out n=%0d got=%h/%h/%b exp=%h/%h/%b",
                         n, vga_x, vga_y, game_done, e_vx, e_vy, m_done);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        wait_idle("pre");
        drive(1, 310, 32'hABCD, 0); step();
        drive(1, 2, 0, 0); step();
        drive(0, 3, 0, 1); step();
        drive(0, 3, 0, 0);
        vga_idx = 7'd10;
        for (int i = 0; i < 10; i++) step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if (bus.q_dmem !== 32'd0 || vga_x !== 32'd0 || game_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%h/%h/%b exp=0/0/0",
                     bus.q_dmem, vga_x, game_done);
        end
        step();
        reset = 1'b0;
        step();
        n_chk++;
        if (vga_x !== 32'd0 || bus.q_dmem !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset got=%h/%h exp=0/0", vga_x, bus.q_dmem);
        end
    endtask

    initial begin
        reset = 1'b1;
        button = 3'b000;
        vga_idx = 7'd0;
        bus.ram_q = 32'd0;
        drive(0, 3, 0, 0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_frame();
        test_drop();
        test_copy_preserve();
        test_game_done();
        test_read_mux();
        test_random();
        test_reset_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_frame_ctrl.md
# mmio_frame_ctrl

Memory-mapped I/O controller between the processor's data-memory port and the VGA renderer. It decodes CPU loads and stores for the button, game-done, commit and status registers, and for the object position tables. It double-buffers the 100-entry X/Y position tables so the renderer never shows a half-written frame: the CPU fills the back bank, commits, and the controller swaps banks at the next vertical sync, then copies the new front bank into the back bank.

## Interface
Parameters:
- N_OBJ, 100, number of objects per table (index width 7)
- X_BASE, 300, word address of x[0]
- Y_BASE, 400, word address of y[0]
- BTN_ADDR, 0, button read register
- DONE_ADDR, 1, game-done register
- COMMIT_ADDR, 2, frame commit register (write-only)
- STATUS_ADDR, 3, status register (read-only)

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- wren  in  1  CPU store enable
- address_dmem  in  12  CPU word address
- data  in  32  CPU store data
- ram_q  in  32  read data from RAM
- q_dmem  out  32  read data returned to CPU
- button  in  3  debounced button code
- vsync_pulse  in  1  one-cycle pulse at start of vertical blank, already in the clock domain
- vga_idx  in  7  renderer object index
- vga_x  out  32  front-bank x[vga_idx], registered
- vga_y  out  32  front-bank y[vga_idx], registered
- game_done  out  1  sticky game-over flag

## Operation
- Storage: banks 0 and 1, each holding x and y arrays of N_OBJ × 32 bits. Register `front` (1 bit) selects the bank the renderer reads; the back bank is `~front`.
- FSM states:
  - IDLE: position stores land in the back bank.
    - Store to X_BASE+i writes x[i]; store to Y_BASE+i writes y[i], for 0 ≤ i < N_OBJ.
    - Any store to COMMIT_ADDR moves the FSM to PENDING. The data value is ignored.
  - PENDING: waits for vsync_pulse.
    - On vsync_pulse: toggle `front`, increment frame_count (16 bits, wraps 0xFFFF→0), go to COPY.
  - COPY: copies one entry per cycle, k = 0..N_OBJ-1, from the new front bank into the new back bank (x and y together). After k = N_OBJ-1, return to IDLE. Duration is exactly N_OBJ cycles.
- Position stores in PENDING or COPY are dropped and set the sticky `drop` flag. Commit stores in PENDING or COPY are ignored and do not set `drop`.
- A store in the same cycle as the IDLE→PENDING commit is impossible, since there is one store per cycle.
- vsync_pulse in IDLE or COPY is ignored.
- Read mux on q_dmem is combinational on address_dmem:
  - BTN_ADDR → {29'b0, button}
  - DONE_ADDR → {31'b0, game_done}
  - STATUS_ADDR → {frame_count, 14'b0, drop, busy}, where busy = (state ≠ IDLE)
  - all other addresses → ram_q, including the position ranges; position tables are not readable by the CPU.
- Clear-on-read: a load of STATUS_ADDR (address_dmem == STATUS_ADDR with wren = 0) clears `drop` on the following edge. If a drop occurs in the same cycle, `drop` stays set.
- game_done sets when wren && address_dmem == DONE_ADDR && data ≠ 0. Only reset clears it.
- RAM wren passthrough is outside this block. Stores to mapped addresses still reach RAM; the Wrapper gates this.
- Renderer port: vga_x/vga_y <= front-bank entry at vga_idx. If vga_idx ≥ N_OBJ, the outputs are 0.

## Timing
- Reset (asynchronous): all bank entries 0, front = 0, state IDLE, frame_count 0, drop 0, game_done 0, vga_x/vga_y 0, copy index 0.
- Store-to-back-bank latency: 1 edge.
- Commit to swap: from 1 cycle (vsync_pulse in the cycle after the commit edge) upward, unbounded while waiting. A vsync_pulse in the same cycle as the commit store is not seen; the swap waits for the next pulse.
- The front toggle and the first copy (k = 0) happen on consecutive edges. busy is high from the edge after commit through the last COPY edge.
- The renderer sees the new frame on vga_x/vga_y one edge after the toggle edge (registered read).
- Mid-operation reset in PENDING or COPY returns to the full reset state immediately.

## Test plan
- Reset release → q_dmem at STATUS_ADDR = 0, vga_x = vga_y = 0 for all indices, game_done = 0.
- In IDLE: store x[5] = 0x64 and y[5] = 0xC8, then commit, then pulse vsync → two cycles later vga_idx = 5 gives vga_x = 0x64, vga_y = 0xC8. Status shows frame_count 1 and busy = 1 for exactly 100 cycles after the toggle edge, then 0.
- Store x[7] = 9 while PENDING → drop = 1, and after the swap vga_x[7] keeps its old value. A STATUS load returns bit1 = 1; the next STATUS load returns bit1 = 0.
- After swap and COPY complete: store x[5] = 1, commit, vsync → vga_x[5] = 1 and vga_y[5] still 0xC8, since COPY preserved the entry.
- Store DONE_ADDR = 0 → game_done stays 0. Store DONE_ADDR = 3 → game_done = 1; a later store of 0 keeps it at 1. Assert reset mid-COPY → all state returns to reset values.
- button = 3'b101, load BTN_ADDR → q_dmem = 5. Load address 50 → q_dmem = ram_q. vga_idx = 120 → vga_x = 0.
